vga_rect_arbiter: RTL and testbench
===================================

// Module: vga_rect_arbiter
// PURPOSE
//  Shares the single VGA adapter write port (x, y, colour, writeEn) between NUM_REQ drawing clients
//  (brush stamper, cursor draw/erase, canvas clear). Each client requests one filled rectangle.
//  Round-robin grant, then a raster pixel sequencer emits one clipped pixel write per cycle.
//  Sits between the interface datapath/control blocks and vga_adapter, on CLOCK.
// PARAMETERS
//  NUM_REQ   3    number of requesters (2..8)
//  X_W       8    x coordinate width
//  Y_W       7    y coordinate width
//  COLOUR_W  15   pixel colour width (5 bits per channel)
//  XMAX      159  last visible column; writes with x>XMAX are never issued
//  YMAX      119  last visible row; writes with y>YMAX are never issued
// PORTS
//  CLOCK       in   1                  system clock, all logic rising-edge
//  resetn      in   1                  asynchronous, active-low reset
//  req         in   NUM_REQ            per-client request level
//  req_x       in   NUM_REQ*X_W        packed rect origin x, client i at [i*X_W +: X_W]
//  req_y       in   NUM_REQ*Y_W        packed rect origin y
//  req_w       in   NUM_REQ*X_W        packed rect width in pixels (0 = empty)
//  req_h       in   NUM_REQ*Y_W        packed rect height in pixels (0 = empty)
//  req_colour  in   NUM_REQ*COLOUR_W   packed fill colour
//  grant       out  NUM_REQ            one-hot, high for the whole owned transaction
//  done        out  NUM_REQ            one-hot, 1-cycle pulse at end of owned transaction
//  busy        out  1                  high in any state except IDLE
//  x           out  X_W                pixel x to vga_adapter (registered)
//  y           out  Y_W                pixel y to vga_adapter (registered)
//  colour      out  COLOUR_W           pixel colour to vga_adapter (registered)
//  writeEn     out  1                  pixel write strobe to vga_adapter (registered)
// BEHAVIOUR
//  - Reset (async, resetn=0): all outputs 0, state IDLE, rr pointer = NUM_REQ-1 (client 0 wins first).
//    Reset mid-transaction aborts it immediately: no done, no further writes.
//  - FSM IDLE -> LOAD -> DRAW -> DONE -> IDLE.
//    IDLE: if any req, pick first set bit starting at (ptr+1) mod NUM_REQ; register grant; -> LOAD.
//    LOAD: latch winner's x/y/w/h/colour; clip: w_eff = (x>XMAX)?0:min(w,XMAX+1-x), h_eff likewise
//          vs YMAX, computed at X_W+1 / Y_W+1 bits (no wrap). If w_eff==0 or h_eff==0 -> DONE, else -> DRAW.
//    DRAW: one writeEn per cycle, x inner loop origin..origin+w_eff-1, then y++; after last pixel -> DONE.
//    DONE: done[winner]=1 for this cycle only; ptr <= winner; grant cleared on exit; -> IDLE.
//  - Latency: req seen in IDLE at cycle N -> grant high from N+1; first writeEn at N+2;
//    writeEn high exactly w_eff*h_eff consecutive cycles; done at N+2+w_eff*h_eff; grant low next cycle.
//    Per-rect overhead 3 cycles (IDLE, LOAD, DONE).
//  - Handshake: client holds req and params stable until grant; params are sampled only in LOAD.
//    Dropping req after grant does not abort; the rectangle completes and done still pulses.
//    req still high in the cycle after done is a new request and re-arbitrates fairly.
//  - Simultaneous requests: strict round-robin; a continuously requesting client waits at most
//    NUM_REQ-1 transactions. Requests arriving outside IDLE wait; nothing is queued beyond req levels.
//  - writeEn=0 in IDLE, LOAD, DONE; x/y/colour hold last value when writeEn=0.
//  - Only the granted client's done bit may be set; grant and done are never set for two clients.
// STRUCTURE
//  - Shared include vga_draw_defs.vh: X_W/Y_W/COLOUR_W defaults, XMAX/YMAX, FSM state encodings
//    (ST_IDLE, ST_LOAD, ST_DRAW, ST_DONE); reused by other drawing clients.
//  - Sub-module rr_arbiter (NUM_REQ): combinational pick from req + ptr, outputs one-hot winner and
//    index; pointer register lives in vga_rect_arbiter (updated in DONE).
//  - Top holds latched rect, clip arithmetic, x/y counters, output registers.
// TESTING
//  1. Single req0: x=10,y=14,w=3,h=2,colour=7FFF -> grant[0] next cycle; 6 writes
//     (10,14)(11,14)(12,14)(10,15)(11,15)(12,15) on consecutive cycles; done[0] one cycle after last.
//  2. req0,req1,req2 asserted together and held -> grant order 0,1,2,0,1,...; no two grants overlap;
//     each done pulses exactly once per transaction.
//  3. Clip: x=158,y=118,w=5,h=4 -> writes only (158,118)(159,118)(158,119)(159,119); x=200 -> 0 writes, done.
//  4. w=0 or h=0 -> no writeEn, done at N+2, grant low at N+3.
//  5. resetn low during DRAW of a 4x4 rect after 5 writes -> all outputs 0 at once, no done;
//     after release, req0 still high -> fresh full 16-write transaction.
//  6. Client drops req one cycle after grant, params changed -> rectangle drawn with LOAD-time params; done pulses.

Source files
------------

// File: rtl/vga_rect_arbiter_pkg.sv
// Shared drawing constants, FSM state encoding and clip helper for the rectangle arbiter.
// Pure declarations: no logic, no latency.
package vga_rect_arbiter_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 15;
    localparam int XMAX     = 159;
    localparam int YMAX     = 119;

    // One past the last visible column/row; one bit wider so the span itself fits
    localparam logic [X_W:0] X_SPAN = (X_W+1)'(XMAX + 1);
    localparam logic [Y_W:0] Y_SPAN = (Y_W+1)'(YMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Visible run length of a span starting at org; zero when it starts off-screen
    function automatic logic [X_W:0] clip_len(input logic [X_W:0] org,
                                              input logic [X_W:0] len,
                                              input logic [X_W:0] span);
        logic [X_W:0] room;
        room = span - org;
        if (org >= span)
            clip_len = '0;
        else if (len < room)
            clip_len = len;
        else
            clip_len = room;
    endfunction

endpackage

// File: rtl/vga_rect_arbiter_if.sv
// Client request bundle plus the shared VGA pixel write port.
// slave = arbiter side, master = clients/adapter side.
interface vga_rect_arbiter_if #(parameter int NUM_REQ = 3);
    import vga_rect_arbiter_pkg::*;

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*X_W-1:0]      req_x;
    logic [NUM_REQ*Y_W-1:0]      req_y;
    logic [NUM_REQ*X_W-1:0]      req_w;
    logic [NUM_REQ*Y_W-1:0]      req_h;
    logic [NUM_REQ*COLOUR_W-1:0] req_colour;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          done;
    logic                        busy;
    logic [X_W-1:0]              x;
    logic [Y_W-1:0]              y;
    logic [COLOUR_W-1:0]         colour;
    logic                        writeEn;

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_colour,
        output grant, done, busy, x, y, colour, writeEn
    );

    modport master (
        output req, req_x, req_y, req_w, req_h, req_colour,
        input  grant, done, busy, x, y, colour, writeEn
    );

endinterface

// File: rtl/vga_rect_arbiter_rr.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping.
// Zero latency; no state, the caller owns and advances the pointer.
module vga_rect_arbiter_rr #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               vld_o,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   idx_o
);

    int cand;

    always_comb begin
        vld_o = 1'b0;
        win_o = '0;
        idx_o = '0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                win_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/vga_rect_arbiter.sv
// Round-robin owner of the VGA write port; streams one clipped pixel per cycle for the granted rect.
// Grant one cycle after req, first write two cycles after req, done right after the last write.
module vga_rect_arbiter
    import vga_rect_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                 CLOCK,
    input  logic                 resetn,
    vga_rect_arbiter_if.slave    bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [X_W-1:0]       x_q, x_d, org_x_q, org_x_d, last_x_q, last_x_d;
    logic [Y_W-1:0]       y_q, y_d, last_y_q, last_y_d;
    logic [COLOUR_W-1:0]  colour_q, colour_d;
    logic                 wen_q, wen_d;

    logic                 arb_vld;
    logic [NUM_REQ-1:0]   arb_win;
    logic [IDX_W-1:0]     arb_idx;

    logic [X_W-1:0]       sel_x, sel_w;
    logic [Y_W-1:0]       sel_y, sel_h;
    logic [COLOUR_W-1:0]  sel_colour;
    logic [X_W:0]         w_eff;
    logic [Y_W:0]         h_eff;

    vga_rect_arbiter_rr #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .vld_o (arb_vld),
        .win_o (arb_win),
        .idx_o (arb_idx)
    );

    // Winner's parameters are only consumed in LOAD, where win_q is already settled
    assign sel_x      = bus.req_x[win_q*X_W +: X_W];
    assign sel_y      = bus.req_y[win_q*Y_W +: Y_W];
    assign sel_w      = bus.req_w[win_q*X_W +: X_W];
    assign sel_h      = bus.req_h[win_q*Y_W +: Y_W];
    assign sel_colour = bus.req_colour[win_q*COLOUR_W +: COLOUR_W];

    assign w_eff = clip_len({1'b0, sel_x}, {1'b0, sel_w}, X_SPAN);
    assign h_eff = (Y_W+1)'(clip_len((X_W+1)'(sel_y), (X_W+1)'(sel_h), (X_W+1)'(Y_SPAN)));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        wen_d    = wen_q;
        org_x_d  = org_x_q;
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_win;
                    win_d   = arb_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_eff == '0 || h_eff == '0) begin
                    state_d = ST_DONE;
                end else begin
                    // Present the first pixel straight away so DRAW starts with a live write
                    x_d      = sel_x;
                    y_d      = sel_y;
                    colour_d = sel_colour;
                    wen_d    = 1'b1;
                    org_x_d  = sel_x;
                    last_x_d = sel_x + w_eff[X_W-1:0] - 1'b1;
                    last_y_d = sel_y + h_eff[Y_W-1:0] - 1'b1;
                    state_d  = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (x_q == last_x_q) begin
                    if (y_q == last_y_q) begin
                        wen_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        x_d = org_x_q;
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                ptr_d   = win_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            win_q    <= '0;
            ptr_q    <= IDX_W'(NUM_REQ - 1);
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            wen_q    <= 1'b0;
            org_x_q  <= '0;
            last_x_q <= '0;
            last_y_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            wen_q    <= wen_d;
            org_x_q  <= org_x_d;
            last_x_q <= last_x_d;
            last_y_q <= last_y_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = (state_q == ST_DONE) ? grant_q : '0;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.colour  = colour_q;
    assign bus.writeEn = wen_q;

endmodule

// File: tb/tb_vga_rect_arbiter.sv
// Randomised bench for vga_rect_arbiter against a pixel-list / round-robin reference model.
module tb_vga_rect_arbiter;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   mptr   = 2;

    int px[3], py[3], pw[3], ph[3], pc[3];
    int g_cyc, g_val, d_cyc, d_val, d_cnt, g_after, bad;
    int cx[$], cy[$], cc[$], cw[$];

    vga_rect_arbiter_if #(.NUM_REQ(3)) bus();

    vga_rect_arbiter #(.NUM_REQ(3)) dut (
        .CLOCK  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int eff(input int o, input int len, input int mx);
        if (o > mx) return 0;
        return (len < mx + 1 - o) ? len : mx + 1 - o;
    endfunction

    task automatic set_client(input int i, input int x, input int y, input int w, input int h, input int c);
        bus.req_x[i*8 +: 8]        = 8'(x);
        bus.req_y[i*7 +: 7]        = 7'(y);
        bus.req_w[i*8 +: 8]        = 8'(w);
        bus.req_h[i*7 +: 7]        = 7'(h);
        bus.req_colour[i*15 +: 15] = 15'(c);
        px[i] = x; py[i] = y; pw[i] = w; ph[i] = h; pc[i] = c;
    endtask

    // Records one owned transaction: grant edge, every pixel write, done pulse, grant after done
    task automatic capture(input bit drop, input bit scramble);
        int gi;
        g_cyc = -1; g_val = 0; d_cyc = -1; d_val = 0; d_cnt = 0; g_after = -1; bad = 0;
        cx.delete(); cy.delete(); cc.delete(); cw.delete();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (d_cyc >= 0) begin
                g_after = int'(bus.grant);
                break;
            end
            if (bus.grant != 0 && g_cyc < 0) begin
                g_cyc = cyc;
                g_val = int'(bus.grant);
            end
            if (drop && g_cyc >= 0 && cyc == g_cyc + 1) begin
                bus.req = bus.req & ~g_val[2:0];
                if (scramble) begin
                    gi = $clog2(g_val);
                    set_client(gi, $urandom_range(0, 150), $urandom_range(0, 110),
                               $urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(0, 32767));
                end
            end
            if (bus.writeEn) begin
                cx.push_back(int'(bus.x)); cy.push_back(int'(bus.y));
                cc.push_back(int'(bus.colour)); cw.push_back(cyc);
            end
            if (bus.done != 0) begin
                d_cnt++;
                if (d_cyc < 0) begin d_cyc = cyc; d_val = int'(bus.done); end
            end
            if (!$onehot0(bus.grant) || (bus.done != 0 && bus.done != bus.grant)) bad = 1;
        end
    endtask

    task automatic test_reset();
        int n;
        bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0; bus.req_colour = '0;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) set_client(i, 5 + i, 5, 2, 1, 100 + i);
        bus.req = 3'b111;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.grant !== 0 || bus.done !== 0 || bus.busy !== 0 || bus.writeEn !== 0 ||
            bus.x !== 0 || bus.y !== 0 || bus.colour !== 0)
            begin errors++; $display("FAIL reset_outputs: grant=%0d done=%0d busy=%0d we=%0d x=%0d y=%0d c=%0h, want all 0",
                bus.grant, bus.done, bus.busy, bus.writeEn, bus.x, bus.y, bus.colour); end
        resetn = 1'b1;
        mptr = 2;
        @(negedge clk);
        checks++;
        if (bus.grant !== 3'b001) begin errors++; $display("FAIL reset_first_winner: grant=%b want 001", bus.grant); end
        bus.req = '0;
        n = 0;
        while (bus.busy && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_first_txn_end: busy=%0d after %0d cycles want 0", bus.busy, n); end
        mptr = 0;
    endtask

    task automatic test_single();
        int N, cl, ex, ey, ew, eh, ec, n, k, ax, ay, ac, aw;
        cl = 0; ex = 10; ey = 14; ew = 3; eh = 2; ec = 'h7fff;
        @(posedge clk); #1;
        set_client(cl, ex, ey, ew, eh, ec);
        bus.req = 3'b001; N = cyc;
        capture(1'b1, 1'b0);
        mptr = cl;
        n = eff(ex, ew, 159) * eff(ey, eh, 119);
        checks++; if (g_val !== (1 << cl) || g_cyc !== N + 1) begin errors++;
            $display("FAIL single_grant: got %0d at %0d want %0d at %0d", g_val, g_cyc, 1 << cl, N + 1); end
        checks++; if (cx.size() !== n) begin errors++; $display("FAIL single_count: got %0d want %0d", cx.size(), n); end
        k = 0;
        for (int yy = ey; yy < ey + eff(ey, eh, 119); yy++)
            for (int xx = ex; xx < ex + eff(ex, ew, 159); xx++) begin
                ax = -1; ay = -1; ac = -1; aw = -1;
                if (k < cx.size()) begin ax = cx[k]; ay = cy[k]; ac = cc[k]; aw = cw[k]; end
                checks++;
                if (ax !== xx || ay !== yy || ac !== ec || aw !== N + 2 + k) begin errors++;
                    $display("FAIL single_pixel%0d: got (%0d,%0d) c=%0h @%0d want (%0d,%0d) c=%0h @%0d",
                             k, ax, ay, ac, aw, xx, yy, ec, N + 2 + k); end
                k++;
            end
        checks++; if (d_val !== (1 << cl) || d_cyc !== N + 2 + n || d_cnt !== 1) begin errors++;
            $display("FAIL single_done: got %0d at %0d x%0d want %0d at %0d x1", d_val, d_cyc, d_cnt, 1 << cl, N + 2 + n); end
        checks++; if (g_after !== 0 || bad !== 0) begin errors++;
            $display("FAIL single_release: grant_after=%0d bad=%0d want 0 0", g_after, bad); end
    endtask

    task automatic test_clip_empty();
        int tx[5] = '{158, 200, 30, 30, 150};
        int ty[5] = '{118, 10, 40, 40, 125};
        int tw[5] = '{5, 3, 0, 5, 2};
        int th[5] = '{4, 3, 5, 0, 2};
        int N, cl, ex, ey, ew, eh, ec, n, k, ax, ay, ac, aw;
        for (int t = 0; t < 11; t++) begin
            if (t < 5) begin
                cl = t % 3; ex = tx[t]; ey = ty[t]; ew = tw[t]; eh = th[t];
            end else begin
                cl = $urandom_range(0, 2); ex = $urandom_range(0, 255); ey = $urandom_range(0, 127);
                ew = $urandom_range(0, 5); eh = $urandom_range(0, 4);
                if (t > 7) ex = $urandom_range(140, 170);
            end
            ec = $urandom_range(0, 32767);
            @(posedge clk); #1;
            set_client(cl, ex, ey, ew, eh, ec);
            bus.req = 3'(1 << cl); N = cyc;
            capture(1'b1, 1'b0);
            mptr = cl;
            n = eff(ex, ew, 159) * eff(ey, eh, 119);
            checks++; if (g_val !== (1 << cl) || g_cyc !== N + 1) begin errors++;
                $display("FAIL clip%0d_grant: got %0d at %0d want %0d at %0d", t, g_val, g_cyc, 1 << cl, N + 1); end
            checks++; if (cx.size() !== n) begin errors++; $display("FAIL clip%0d_count: got %0d want %0d", t, cx.size(), n); end
            k = 0;
            for (int yy = ey; yy < ey + eff(ey, eh, 119); yy++)
                for (int xx = ex; xx < ex + eff(ex, ew, 159); xx++) begin
                    ax = -1; ay = -1; ac = -1; aw = -1;
                    if (k < cx.size()) begin ax = cx[k]; ay = cy[k]; ac = cc[k]; aw = cw[k]; end
                    checks++;
                    if (ax !== xx || ay !== yy || ac !== ec || aw !== N + 2 + k) begin errors++;
                        $display("FAIL clip%0d_pixel%0d: got (%0d,%0d) c=%0h @%0d want (%0d,%0d) c=%0h @%0d",
                                 t, k, ax, ay, ac, aw, xx, yy, ec, N + 2 + k); end
                    k++;
                end
            checks++; if (d_val !== (1 << cl) || d_cyc !== N + 2 + n || d_cnt !== 1) begin errors++;
                $display("FAIL clip%0d_done: got %0d at %0d x%0d want %0d at %0d x1", t, d_val, d_cyc, d_cnt, 1 << cl, N + 2 + n); end
            checks++; if (g_after !== 0 || bad !== 0) begin errors++;
                $display("FAIL clip%0d_release: grant_after=%0d bad=%0d want 0 0", t, g_after, bad); end
        end
    endtask

    task automatic test_drop_req();
        int N, cl, ex, ey, ew, eh, ec, n, k, ax, ay, ac, aw;
        cl = 1; ex = 5; ey = 6; ew = 3; eh = 2; ec = 'h1a2b;
        @(posedge clk); #1;
        set_client(cl, ex, ey, ew, eh, ec);
        bus.req = 3'b010; N = cyc;
        capture(1'b1, 1'b1);
        mptr = cl;
        n = eff(ex, ew, 159) * eff(ey, eh, 119);
        checks++; if (g_val !== (1 << cl) || g_cyc !== N + 1) begin errors++;
            $display("FAIL drop_grant: got %0d at %0d want %0d at %0d", g_val, g_cyc, 1 << cl, N + 1); end
        checks++; if (cx.size() !== n) begin errors++; $display("FAIL drop_count: got %0d want %0d", cx.size(), n); end
        k = 0;
        for (int yy = ey; yy < ey + eh; yy++)
            for (int xx = ex; xx < ex + ew; xx++) begin
                ax = -1; ay = -1; ac = -1; aw = -1;
                if (k < cx.size()) begin ax = cx[k]; ay = cy[k]; ac = cc[k]; aw = cw[k]; end
                checks++;
                if (ax !== xx || ay !== yy || ac !== ec || aw !== N + 2 + k) begin errors++;
                    $display("FAIL drop_pixel%0d: got (%0d,%0d) c=%0h @%0d want (%0d,%0d) c=%0h @%0d",
                             k, ax, ay, ac, aw, xx, yy, ec, N + 2 + k); end
                k++;
            end
        checks++; if (d_val !== (1 << cl) || d_cyc !== N + 2 + n || d_cnt !== 1 || g_after !== 0) begin errors++;
            $display("FAIL drop_done: got %0d at %0d x%0d grant_after=%0d want %0d at %0d x1 grant_after=0",
                     d_val, d_cyc, d_cnt, g_after, 1 << cl, N + 2 + n); end
    endtask

    task automatic test_round_robin();
        int N, cl, ex, ey, ew, eh, ec, n, k, ax, ay, ac, aw;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            set_client(i, $urandom_range(140, 175), $urandom_range(100, 125), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 32767));
        bus.req = 3'b111; N = cyc;
        for (int t = 0; t < 7; t++) begin
            cl = (mptr + 1) % 3;
            ex = px[cl]; ey = py[cl]; ew = pw[cl]; eh = ph[cl]; ec = pc[cl];
            capture(1'b0, 1'b0);
            mptr = cl;
            n = eff(ex, ew, 159) * eff(ey, eh, 119);
            checks++; if (g_val !== (1 << cl) || g_cyc !== N + 1) begin errors++;
                $display("FAIL rr%0d_grant: got %0d at %0d want %0d at %0d", t, g_val, g_cyc, 1 << cl, N + 1); end
            checks++; if (cx.size() !== n) begin errors++; $display("FAIL rr%0d_count: got %0d want %0d", t, cx.size(), n); end
            k = 0;
            for (int yy = ey; yy < ey + eff(ey, eh, 119); yy++)
                for (int xx = ex; xx < ex + eff(ex, ew, 159); xx++) begin
                    ax = -1; ay = -1; ac = -1; aw = -1;
                    if (k < cx.size()) begin ax = cx[k]; ay = cy[k]; ac = cc[k]; aw = cw[k]; end
                    checks++;
                    if (ax !== xx || ay !== yy || ac !== ec || aw !== N + 2 + k) begin errors++;
                        $display("FAIL rr%0d_pixel%0d: got (%0d,%0d) c=%0h @%0d want (%0d,%0d) c=%0h @%0d",
                                 t, k, ax, ay, ac, aw, xx, yy, ec, N + 2 + k); end
                    k++;
                end
            checks++; if (d_val !== (1 << cl) || d_cyc !== N + 2 + n || d_cnt !== 1 || g_after !== 0 || bad !== 0) begin errors++;
                $display("FAIL rr%0d_done: got %0d at %0d x%0d grant_after=%0d bad=%0d want %0d at %0d x1 0 0",
                         t, d_val, d_cyc, d_cnt, g_after, bad, 1 << cl, N + 2 + n); end
            // The finished client is idle now, so its parameters may change before it next wins
            set_client(cl, $urandom_range(140, 175), $urandom_range(100, 125), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 32767));
            N = d_cyc + 1;
        end
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int N, cl, ex, ey, ew, eh, ec, n, k, nw, nd, ax, ay, ac, aw;
        bit hit;
        cl = 0; ex = 20; ey = 30; ew = 4; eh = 4; ec = 'h1234;
        @(posedge clk); #1;
        set_client(cl, ex, ey, ew, eh, ec);
        bus.req = 3'b001; nw = 0; hit = 0;
        for (int t = 0; t < 40 && !hit; t++) begin
            @(negedge clk);
            if (bus.writeEn) nw++;
            if (nw == 5) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rmid_reach: saw %0d writes want 5", nw); end
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.grant !== 0 || bus.done !== 0 || bus.busy !== 0 || bus.writeEn !== 0 ||
            bus.x !== 0 || bus.y !== 0 || bus.colour !== 0)
            begin errors++; $display("FAIL rmid_outputs: grant=%0d done=%0d busy=%0d we=%0d x=%0d y=%0d c=%0h, want all 0",
                bus.grant, bus.done, bus.busy, bus.writeEn, bus.x, bus.y, bus.colour); end
        nd = 0;
        repeat (3) begin @(negedge clk); if (bus.done !== 0 || bus.writeEn !== 0) nd++; end
        checks++; if (nd !== 0) begin errors++; $display("FAIL rmid_quiet: %0d cycles with done/write want 0", nd); end
        resetn = 1'b1; mptr = 2; N = cyc;
        capture(1'b1, 1'b0);
        mptr = cl;
        n = ew * eh;
        checks++; if (g_val !== 1 || g_cyc !== N + 1 || cx.size() !== n) begin errors++;
            $display("FAIL rmid_restart: grant %0d at %0d, %0d writes want 1 at %0d, %0d writes", g_val, g_cyc, cx.size(), N + 1, n); end
        k = 0;
        for (int yy = ey; yy < ey + eh; yy++)
            for (int xx = ex; xx < ex + ew; xx++) begin
                ax = -1; ay = -1; ac = -1; aw = -1;
                if (k < cx.size()) begin ax = cx[k]; ay = cy[k]; ac = cc[k]; aw = cw[k]; end
                checks++;
                if (ax !== xx || ay !== yy || ac !== ec || aw !== N + 2 + k) begin errors++;
                    $display("FAIL rmid_pixel%0d: got (%0d,%0d) c=%0h @%0d want (%0d,%0d) c=%0h @%0d",
                             k, ax, ay, ac, aw, xx, yy, ec, N + 2 + k); end
                k++;
            end
        checks++; if (d_val !== 1 || d_cyc !== N + 2 + n || d_cnt !== 1 || g_after !== 0) begin errors++;
            $display("FAIL rmid_done: got %0d at %0d x%0d grant_after=%0d want 1 at %0d x1 0", d_val, d_cyc, d_cnt, g_after, N + 2 + n); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clip_empty();
        test_drop_req();
        test_round_robin();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
